// File: rtl/pio_pkg.sv
// pio_pkg: register map and mode encodings shared by the PIO input capture block
package pio_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;
endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: input synchronizer, delayed copy, arming counter and edge detection
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] edge_o
);
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int AW      = $clog2(ARM_MAX + 1);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] raw;
  logic [AW-1:0]    arm_q, arm_d;
  logic             armed;
  assign data_o = sync_q[SYNC_STAGES-1];
  // edges stay masked until reset-time garbage has flushed through the chain and prev
  assign armed  = arm_q == AW'(ARM_MAX);
  assign arm_d  = armed ? arm_q : arm_q + 1'b1;
  assign raw    = EDGE_MODE == EDGE_RISE ? data_o & ~prev_q :
                  EDGE_MODE == EDGE_FALL ? ~data_o & prev_q : data_o ^ prev_q;
  assign edge_o = armed ? raw : '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q[0] <= in_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= data_o;
      arm_q  <= arm_d;
    end
  end
endmodule

// File: rtl/pio_in_capture.sv
// pio_in_capture: synchronized parallel input port with edge capture, irq mask and bus readback
module pio_in_capture
  import pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int IRQ_MODE    = IRQ_LEVEL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] data, edges, wdata;
  logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d;
  logic [31:0]      rd_d;
  logic             wr;
  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_MODE  (EDGE_MODE)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .in_i   (in_port),
    .data_o (data),
    .edge_o (edges)
  );
  assign wr    = chipselect & ~write_n;
  assign wdata = WIDTH'(writedata);
  // a new edge wins over a same-cycle clear so no event is lost
  always_comb begin
    mask_d = wr && address == ADDR_MASK ? wdata : mask_q;
    cap_d  = (cap_q & ~(wr && address == ADDR_EDGE ? wdata : '0)) | edges;
    rd_d   = address == ADDR_DATA ? 32'(data) :
             address == ADDR_MASK ? 32'(mask_q) :
             address == ADDR_EDGE ? 32'(cap_q) : 32'h0;
  end
  assign irq = IRQ_MODE == IRQ_EDGE ? |(cap_q & mask_q) : |(data & mask_q);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      cap_q    <= '0;
      readdata <= '0;
    end else begin
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      readdata <= rd_d;
    end
  end
endmodule

// File: tb/tb_pio_in_capture.sv
// tb_pio_in_capture: four mode variants against a latency-level behavioural model plus literal checks
module tb_pio_in_capture;
  localparam int S = 2;
  localparam int EM [4] = '{0, 0, 1, 2};
  localparam int IM [4] = '{0, 1, 1, 0};
  logic        clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = 32'h0;
  logic [7:0]  in_port = 8'h0;
  logic [31:0] rd [4];
  logic        irq [4];
  int          vecs = 0, errs = 0;
  always #5 clk = ~clk;
  genvar g;
  for (g = 0; g < 4; g++) begin : g_dut
    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_MODE(EM[g]), .IRQ_MODE(IM[g])) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .in_port   (in_port),
      .readdata  (rd[g]),
      .irq       (irq[g])
    );
  end
  // model: data shows the input sampled S-1 edges ago; edges count only once S+1 edges have passed since reset
  logic [7:0]  hist [$];
  int          arm = 0;
  logic [7:0]  m_dat = 8'h0, m_prev = 8'h0, m_mask = 8'h0, clr;
  logic [7:0]  m_ec [4] = '{default: 8'h0};
  logic [31:0] m_rd [4] = '{default: 32'h0};
  function automatic logic [7:0] edge_of(int m, logic [7:0] d, logic [7:0] p);
    return m == 0 ? d & ~p : m == 1 ? ~d & p : d ^ p;
  endfunction
  function automatic logic m_irq(int i);
    return IM[i] == 0 ? |(m_dat & m_mask) : |(m_ec[i] & m_mask);
  endfunction
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist.delete();
      arm = 0;
      m_dat = 8'h0;
      m_prev = 8'h0;
      m_mask = 8'h0;
      for (int i = 0; i < 4; i++) begin
        m_ec[i] = 8'h0;
        m_rd[i] = 32'h0;
      end
    end else begin
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h0;
      for (int i = 0; i < 4; i++) begin
        m_rd[i] = address == 2'd0 ? {24'h0, m_dat} : address == 2'd2 ? {24'h0, m_mask} :
                  address == 2'd3 ? {24'h0, m_ec[i]} : 32'h0;
        m_ec[i] = (m_ec[i] & ~clr) | (arm > S ? edge_of(EM[i], m_dat, m_prev) : 8'h0);
      end
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[7:0];
      if (arm <= S) arm++;
      hist.push_back(in_port);
      if (hist.size() > S) void'(hist.pop_front());
      m_prev = m_dat;
      m_dat = hist.size() == S ? hist[0] : 8'h0;
    end
  end
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("model_rd%0d", i), rd[i], m_rd[i]);
        check($sformatf("model_irq%0d", i), {31'h0, irq[i]}, {31'h0, m_irq(i)});
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(logic [1:0] a, logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask
  initial begin
    tick(3);
    check("reset_rd", rd[0], 32'h0);
    check("reset_irq", {31'h0, irq[0]}, 32'h0);
    reset_n = 1'b1;
    tick(6);
    address = 2'd0;
    in_port = 8'h5A;
    tick(1);
    check("sync_edge_k", rd[0], 32'h0);
    tick(1);
    check("sync_edge_k1", rd[0], 32'h0);
    tick(1);
    check("sync_edge_k2", rd[0], 32'h5A);
    in_port = 8'h00;
    tick(4);
    wr(2'd3, 32'hFF);
    tick(2);
    in_port = 8'h08;
    tick(1);
    in_port = 8'h00;
    tick(4);
    address = 2'd3;
    tick(1);
    check("capture_bit3", rd[0], 32'h08);
    wr(2'd3, 32'h08);
    tick(1);
    check("w1c_clear", rd[0], 32'h00);
    in_port = 8'h01;
    tick(4);
    in_port = 8'h00;
    tick(4);
    in_port = 8'h01;
    tick(2);
    wr(2'd3, 32'h01);
    tick(1);
    check("set_over_clear", rd[0], 32'h01);
    in_port = 8'h00;
    tick(4);
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'h81);
    in_port = 8'h80;
    tick(3);
    check("irq_level", {31'h0, irq[0]}, 32'h1);
    wr(2'd2, 32'h01);
    wr(2'd3, 32'hFF);
    in_port = 8'h82;
    tick(4);
    check("irq_edge_masked", {31'h0, irq[1]}, 32'h0);
    address = 2'd3;
    tick(1);
    check("capture_0x02", rd[1], 32'h02);
    in_port = 8'h83;
    tick(4);
    check("irq_edge_hit", {31'h0, irq[1]}, 32'h1);
    in_port = 8'hFF;
    reset_n = 1'b0;
    tick(2);
    check("reset_mid_irq", {31'h0, irq[1]}, 32'h0);
    check("reset_mid_rd", rd[1], 32'h0);
    reset_n = 1'b1;
    tick(8);
    address = 2'd3;
    tick(1);
    check("arm_rise", rd[0], 32'h0);
    check("arm_any", rd[3], 32'h0);
    in_port = 8'h7F;
    tick(4);
    in_port = 8'hFF;
    tick(4);
    tick(1);
    check("rearm_bit7", rd[0], 32'h80);
    wr(2'd1, 32'hFFFFFFFF);
    wr(2'd2, 32'hFFFFFFFF);
    address = 2'd1;
    tick(1);
    check("reserved_reads_0", rd[0], 32'h0);
    address = 2'd2;
    tick(1);
    check("mask_upper_0", rd[0], 32'hFF);
    for (int i = 0; i < 80; i++) begin
      in_port = 8'($urandom);
      if ($urandom_range(0, 3) == 0) wr(2'($urandom_range(2, 3)), $urandom);
      else begin
        address = 2'($urandom_range(0, 3));
        tick(1);
      end
    end
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
